// File: rtl/snake_engine.sv
// snake_engine: snake body engine for the VGA snake game.
// Keeps the body in a circular {x,y} buffer, advances one cell per step,
// detects wall/self collisions, grows on food, and emits a one-pixel-per-cycle
// plot stream (tail erase, head draw) for the vga_adapter.
// Ports:
//   clk, resetn             clock, asynchronous active-low reset
//   step, dir_req           advance request and requested direction (0 L, 1 R, 2 U, 3 D)
//   food_valid/food_x/_y    live food cell
//   plot, x_out, y_out,     pixel write strobe and registered pixel data
//   colour
//   busy                    engine working (INIT or a move in progress)
//   ate                     one-cycle pulse with the DRAW pixel when the snake eats
//   dead                    sticky collision flag
//   length                  current body length
module snake_engine #(
   parameter int X_W      = 8,
   parameter int Y_W      = 7,
   parameter int X_MAX    = 159,
   parameter int Y_MAX    = 119,
   parameter int MAX_LEN  = 64,
   parameter int INIT_LEN = 3,
   parameter int WRAP     = 0
) (
   input  logic                       clk,
   input  logic                       resetn,
   input  logic                       step,
   input  logic [1:0]                 dir_req,
   input  logic                       food_valid,
   input  logic [X_W-1:0]             food_x,
   input  logic [Y_W-1:0]             food_y,
   output logic                       plot,
   output logic [X_W-1:0]             x_out,
   output logic [Y_W-1:0]             y_out,
   output logic [2:0]                 colour,
   output logic                       busy,
   output logic                       ate,
   output logic                       dead,
   output logic [$clog2(MAX_LEN):0]   length
);

   localparam int PW = $clog2(MAX_LEN);
   localparam int LW = PW + 1;
   localparam int X0 = X_MAX / 2;
   localparam int Y0 = Y_MAX / 2;

   typedef enum logic [2:0] {S_INIT, S_IDLE, S_CALC, S_SCAN, S_ERASE, S_DRAW, S_DEAD} state_t;
   typedef enum logic [1:0] {D_LEFT, D_RIGHT, D_UP, D_DOWN} dir_t;

   logic [X_W-1:0] r_bx [MAX_LEN];
   logic [Y_W-1:0] r_by [MAX_LEN];
   state_t         r_state;
   dir_t           r_dir;
   logic [PW-1:0]  r_hp;
   logic [LW-1:0]  r_cnt;
   logic [X_W-1:0] r_nx;
   logic [Y_W-1:0] r_ny;
   logic           r_grow;
   logic           r_coll;

   logic [PW-1:0]  w_tail, w_sidx, w_iidx, w_hnext;
   logic [X_W-1:0] w_hx, w_nx;
   logic [Y_W-1:0] w_hy, w_ny;
   logic           w_out, w_match, w_last, w_rev, w_room;
   logic [1:0]     w_cur;

   assign w_tail  = r_hp - length[PW-1:0] + PW'(1);
   assign w_sidx  = w_tail + r_cnt[PW-1:0];
   assign w_iidx  = r_hp - r_cnt[PW-1:0];
   assign w_hnext = r_hp + PW'(1);
   assign w_hx    = r_bx[r_hp];
   assign w_hy    = r_by[r_hp];
   assign w_last  = (r_cnt == length - LW'(1));
   assign w_room  = (length < LW'(MAX_LEN));
   assign w_cur   = r_dir;
   // Opposite directions share bit 1 and differ in bit 0.
   assign w_rev   = (dir_req[1] == w_cur[1]) && (dir_req[0] != w_cur[0]);
   // The first scanned entry is the tail; it vacates unless the snake grows.
   assign w_match = (r_bx[w_sidx] == r_nx) && (r_by[w_sidx] == r_ny) &&
                    (r_grow || (r_cnt != '0));

   always_comb begin
      w_nx  = w_hx;
      w_ny  = w_hy;
      w_out = 1'b0;
      case (r_dir)
         D_LEFT: begin
            if (w_hx == '0) begin
               if (WRAP != 0) w_nx = X_W'(X_MAX);
               else           w_out = 1'b1;
            end else w_nx = w_hx - X_W'(1);
         end
         D_RIGHT: begin
            if (w_hx >= X_W'(X_MAX)) begin
               if (WRAP != 0) w_nx = '0;
               else           w_out = 1'b1;
            end else w_nx = w_hx + X_W'(1);
         end
         D_UP: begin
            if (w_hy == '0) begin
               if (WRAP != 0) w_ny = Y_W'(Y_MAX);
               else           w_out = 1'b1;
            end else w_ny = w_hy - Y_W'(1);
         end
         default: begin
            if (w_hy >= Y_W'(Y_MAX)) begin
               if (WRAP != 0) w_ny = '0;
               else           w_out = 1'b1;
            end else w_ny = w_hy + Y_W'(1);
         end
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         for (int unsigned j = 0; j < MAX_LEN; j++) begin
            r_bx[j] <= (j < INIT_LEN) ? X_W'(X0 - INIT_LEN + 1 + int'(j)) : '0;
            r_by[j] <= (j < INIT_LEN) ? Y_W'(Y0) : '0;
         end
         r_state <= S_INIT;
         r_dir   <= D_RIGHT;
         r_hp    <= PW'(INIT_LEN - 1);
         r_cnt   <= '0;
         r_nx    <= '0;
         r_ny    <= '0;
         r_grow  <= 1'b0;
         r_coll  <= 1'b0;
         plot    <= 1'b0;
         x_out   <= '0;
         y_out   <= '0;
         colour  <= '0;
         busy    <= 1'b0;
         ate     <= 1'b0;
         dead    <= 1'b0;
         length  <= LW'(INIT_LEN);
      end else begin
         plot <= 1'b0;
         ate  <= 1'b0;
         case (r_state)
            S_INIT: begin
               plot   <= 1'b1;
               x_out  <= r_bx[w_iidx];
               y_out  <= r_by[w_iidx];
               colour <= 3'b010;
               busy   <= 1'b1;
               if (r_cnt == LW'(INIT_LEN - 1)) begin
                  r_cnt   <= '0;
                  r_state <= S_IDLE;
               end else r_cnt <= r_cnt + LW'(1);
            end
            S_IDLE: begin
               busy <= 1'b0;
               if (step) begin
                  busy    <= 1'b1;
                  if (!w_rev) r_dir <= dir_t'(dir_req);
                  r_state <= S_CALC;
               end
            end
            S_CALC: begin
               if (w_out) begin
                  r_state <= S_DEAD;
                  dead    <= 1'b1;
                  busy    <= 1'b0;
                  plot    <= 1'b1;
                  x_out   <= w_hx;
                  y_out   <= w_hy;
                  colour  <= 3'b100;
               end else begin
                  r_nx    <= w_nx;
                  r_ny    <= w_ny;
                  r_grow  <= food_valid && (w_nx == food_x) && (w_ny == food_y);
                  r_coll  <= 1'b0;
                  r_cnt   <= '0;
                  r_state <= S_SCAN;
               end
            end
            S_SCAN: begin
               if (w_last) begin
                  r_cnt <= '0;
                  if (r_coll || w_match) begin
                     r_state <= S_DEAD;
                     dead    <= 1'b1;
                     busy    <= 1'b0;
                     plot    <= 1'b1;
                     x_out   <= w_hx;
                     y_out   <= w_hy;
                     colour  <= 3'b100;
                  end else if (r_grow && w_room) r_state <= S_DRAW;
                  else                           r_state <= S_ERASE;
               end else begin
                  r_coll <= r_coll || w_match;
                  r_cnt  <= r_cnt + LW'(1);
               end
            end
            S_ERASE: begin
               plot    <= 1'b1;
               x_out   <= r_bx[w_tail];
               y_out   <= r_by[w_tail];
               colour  <= 3'b000;
               r_state <= S_DRAW;
            end
            S_DRAW: begin
               r_bx[w_hnext] <= r_nx;
               r_by[w_hnext] <= r_ny;
               r_hp          <= w_hnext;
               plot          <= 1'b1;
               x_out         <= r_nx;
               y_out         <= r_ny;
               colour        <= 3'b010;
               if (r_grow) begin
                  ate <= 1'b1;
                  if (w_room) length <= length + LW'(1);
               end
               r_state <= S_IDLE;
            end
            S_DEAD: busy <= 1'b0;
            default: r_state <= S_DEAD;
         endcase
      end
   end

endmodule

// File: tb/tb_snake_engine.sv
module tb_snake_engine;

   logic       clk = 1'b0;
   logic       resetn = 1'b0;
   logic       step_a [3];
   logic [1:0] dir_a  [3];
   logic       fv_a   [3];
   logic [7:0] fx_a   [3];
   logic [6:0] fy_a   [3];
   logic       plot_a [3];
   logic [7:0] x_a    [3];
   logic [6:0] y_a    [3];
   logic [2:0] col_a  [3];
   logic       busy_a [3];
   logic       ate_a  [3];
   logic       dead_a [3];
   logic [6:0] len0, len1;
   logic [2:0] len2;

   int n_chk = 0;
   int n_pass = 0;
   int n_pl, n_ate, busy_fall;
   int pn [8];
   int px [8];
   int py [8];
   int pc [8];
   int pa [8];

   always #5 clk = ~clk;

   snake_engine u_dut (
      .clk(clk), .resetn(resetn), .step(step_a[0]), .dir_req(dir_a[0]),
      .food_valid(fv_a[0]), .food_x(fx_a[0]), .food_y(fy_a[0]),
      .plot(plot_a[0]), .x_out(x_a[0]), .y_out(y_a[0]), .colour(col_a[0]),
      .busy(busy_a[0]), .ate(ate_a[0]), .dead(dead_a[0]), .length(len0));

   snake_engine #(.WRAP(1)) u_wrap (
      .clk(clk), .resetn(resetn), .step(step_a[1]), .dir_req(dir_a[1]),
      .food_valid(fv_a[1]), .food_x(fx_a[1]), .food_y(fy_a[1]),
      .plot(plot_a[1]), .x_out(x_a[1]), .y_out(y_a[1]), .colour(col_a[1]),
      .busy(busy_a[1]), .ate(ate_a[1]), .dead(dead_a[1]), .length(len1));

   snake_engine #(.MAX_LEN(4)) u_small (
      .clk(clk), .resetn(resetn), .step(step_a[2]), .dir_req(dir_a[2]),
      .food_valid(fv_a[2]), .food_x(fx_a[2]), .food_y(fy_a[2]),
      .plot(plot_a[2]), .x_out(x_a[2]), .y_out(y_a[2]), .colour(col_a[2]),
      .busy(busy_a[2]), .ate(ate_a[2]), .dead(dead_a[2]), .length(len2));

   // Records plots of DUT d for ncyc cycles, sampling on the falling edge;
   // optionally raises step for one cycle at cycle pulse_n.
   task automatic capture(input int d, input int ncyc, input int pulse_n, input logic [1:0] pulse_dir);
      n_pl = 0; n_ate = 0; busy_fall = -1;
      for (int i = 0; i < 8; i++) begin
         pn[i] = -1; px[i] = -1; py[i] = -1; pc[i] = -1; pa[i] = -1;
      end
      for (int n = 1; n <= ncyc; n++) begin
         @(negedge clk);
         step_a[d] = (n == pulse_n);
         if (n == pulse_n) dir_a[d] = pulse_dir;
         if (plot_a[d]) begin
            if (n_pl < 8) begin
               pn[n_pl] = n; px[n_pl] = int'(x_a[d]); py[n_pl] = int'(y_a[d]);
               pc[n_pl] = int'(col_a[d]); pa[n_pl] = int'(ate_a[d]);
            end
            n_pl++;
         end
         if (ate_a[d]) n_ate++;
         if (busy_fall < 0 && !busy_a[d]) busy_fall = n;
      end
   endtask

   task automatic do_move(input int d, input logic [1:0] dr, input int ncyc, input int pulse_n, input logic [1:0] pulse_dir);
      step_a[d] = 1'b1;
      dir_a[d]  = dr;
      @(negedge clk);
      step_a[d] = 1'b0;
      capture(d, ncyc, pulse_n, pulse_dir);
   endtask

   task automatic test_reset;
      for (int d = 0; d < 3; d++) begin
         step_a[d] = 1'b0; dir_a[d] = 2'd1; fv_a[d] = 1'b0; fx_a[d] = '0; fy_a[d] = '0;
      end
      resetn = 1'b0;
      repeat (2) @(negedge clk);
      n_chk++;
      if (plot_a[0] !== 1'b0 || x_a[0] !== 8'd0 || y_a[0] !== 7'd0 || col_a[0] !== 3'd0 ||
          busy_a[0] !== 1'b0 || ate_a[0] !== 1'b0 || dead_a[0] !== 1'b0 || len0 !== 7'd3)
         $display("FAIL reset_values: plot=%b x=%0d y=%0d c=%0d busy=%b ate=%b dead=%b len=%0d, want 0 0 0 0 0 0 0 3",
                  plot_a[0], x_a[0], y_a[0], col_a[0], busy_a[0], ate_a[0], dead_a[0], len0);
      else n_pass++;
      n_chk++;
      if (len2 !== 3'd3) $display("FAIL reset_len_small: got %0d want 3", len2);
      else n_pass++;
      resetn = 1'b1;
      capture(0, 6, 0, 2'd0);
      n_chk++;
      if (n_pl !== 3 || pn[0] !== 1 || px[0] !== 79 || py[0] !== 59 || pc[0] !== 2 ||
          pn[1] !== 2 || px[1] !== 78 || py[1] !== 59 || pc[1] !== 2 ||
          pn[2] !== 3 || px[2] !== 77 || py[2] !== 59 || pc[2] !== 2)
         $display("FAIL init_plots: got n=%0d [%0d:(%0d,%0d)c%0d %0d:(%0d,%0d)c%0d %0d:(%0d,%0d)c%0d] want 3 [1:(79,59)c2 2:(78,59)c2 3:(77,59)c2]",
                  n_pl, pn[0], px[0], py[0], pc[0], pn[1], px[1], py[1], pc[1], pn[2], px[2], py[2], pc[2]);
      else n_pass++;
      n_chk++;
      if (busy_fall !== 4 || len0 !== 7'd3)
         $display("FAIL init_busy: busy low at %0d len=%0d, want 4 len=3", busy_fall, len0);
      else n_pass++;
   endtask

   task automatic test_step;
      do_move(0, 2'd1, 12, 0, 2'd0);
      n_chk++;
      if (pn[0] !== 5 || px[0] !== 77 || py[0] !== 59 || pc[0] !== 0)
         $display("FAIL step_erase: got n=%0d (%0d,%0d) c%0d, want n=5 (77,59) c0", pn[0], px[0], py[0], pc[0]);
      else n_pass++;
      n_chk++;
      if (n_pl !== 2 || pn[1] !== 6 || px[1] !== 80 || py[1] !== 59 || pc[1] !== 2)
         $display("FAIL step_draw: got plots=%0d n=%0d (%0d,%0d) c%0d, want 2 n=6 (80,59) c2", n_pl, pn[1], px[1], py[1], pc[1]);
      else n_pass++;
      n_chk++;
      if (busy_fall !== 7 || n_ate !== 0 || len0 !== 7'd3)
         $display("FAIL step_status: busy low at %0d ate=%0d len=%0d, want 7 0 3", busy_fall, n_ate, len0);
      else n_pass++;
   endtask

   task automatic test_reversal;
      do_move(0, 2'd0, 12, 0, 2'd0);
      n_chk++;
      if (n_pl !== 2 || px[0] !== 78 || py[0] !== 59 || px[1] !== 81 || py[1] !== 59)
         $display("FAIL reversal: got plots=%0d erase (%0d,%0d) draw (%0d,%0d), want 2 (78,59) (81,59)", n_pl, px[0], py[0], px[1], py[1]);
      else n_pass++;
   endtask

   task automatic test_back_to_back;
      do_move(0, 2'd1, 16, 2, 2'd3);
      n_chk++;
      if (n_pl !== 2 || px[0] !== 79 || px[1] !== 82 || py[1] !== 59 || pn[1] !== 6)
         $display("FAIL busy_drop: got plots=%0d erase x=%0d draw n=%0d (%0d,%0d), want 2 79 n=6 (82,59)", n_pl, px[0], pn[1], px[1], py[1]);
      else n_pass++;
   endtask

   task automatic test_food;
      fv_a[0] = 1'b1; fx_a[0] = 8'd83; fy_a[0] = 7'd59;
      do_move(0, 2'd1, 12, 0, 2'd0);
      fv_a[0] = 1'b0;
      n_chk++;
      if (n_pl !== 1 || pn[0] !== 5 || px[0] !== 83 || py[0] !== 59 || pc[0] !== 2 || pa[0] !== 1)
         $display("FAIL food_draw: got plots=%0d n=%0d (%0d,%0d) c%0d ate=%0d, want 1 n=5 (83,59) c2 ate=1", n_pl, pn[0], px[0], py[0], pc[0], pa[0]);
      else n_pass++;
      n_chk++;
      if (n_ate !== 1 || len0 !== 7'd4)
         $display("FAIL food_len: ate pulses=%0d len=%0d, want 1 4", n_ate, len0);
      else n_pass++;
   endtask

   task automatic test_self;
      fv_a[0] = 1'b1; fx_a[0] = 8'd84; fy_a[0] = 7'd59;
      do_move(0, 2'd1, 12, 0, 2'd0);
      fv_a[0] = 1'b0;
      n_chk++;
      if (n_pl !== 1 || pn[0] !== 6 || px[0] !== 84 || len0 !== 7'd5)
         $display("FAIL self_grow: got plots=%0d n=%0d x=%0d len=%0d, want 1 n=6 84 5", n_pl, pn[0], px[0], len0);
      else n_pass++;
      do_move(0, 2'd3, 12, 0, 2'd0);
      n_chk++;
      if (n_pl !== 2 || pn[0] !== 7 || px[0] !== 80 || py[0] !== 59 || pn[1] !== 8 || px[1] !== 84 || py[1] !== 60)
         $display("FAIL self_down: got n=%0d (%0d,%0d) n=%0d (%0d,%0d), want n=7 (80,59) n=8 (84,60)", pn[0], px[0], py[0], pn[1], px[1], py[1]);
      else n_pass++;
      do_move(0, 2'd0, 12, 0, 2'd0);
      n_chk++;
      if (n_pl !== 2 || px[0] !== 81 || py[0] !== 59 || px[1] !== 83 || py[1] !== 60)
         $display("FAIL self_left: got erase (%0d,%0d) draw (%0d,%0d), want (81,59) (83,60)", px[0], py[0], px[1], py[1]);
      else n_pass++;
      do_move(0, 2'd2, 12, 0, 2'd0);
      n_chk++;
      if (n_pl !== 1 || px[0] !== 83 || py[0] !== 60 || pc[0] !== 4 || dead_a[0] !== 1'b1 || busy_a[0] !== 1'b0 || len0 !== 7'd5)
         $display("FAIL self_dead: got plots=%0d (%0d,%0d) c%0d dead=%b busy=%b len=%0d, want 1 (83,60) c4 1 0 5",
                  n_pl, px[0], py[0], pc[0], dead_a[0], busy_a[0], len0);
      else n_pass++;
   endtask

   task automatic test_full_length;
      fv_a[2] = 1'b1; fx_a[2] = 8'd80; fy_a[2] = 7'd59;
      do_move(2, 2'd1, 12, 0, 2'd0);
      n_chk++;
      if (n_pl !== 1 || px[0] !== 80 || n_ate !== 1 || len2 !== 3'd4)
         $display("FAIL full_grow: got plots=%0d x=%0d ate=%0d len=%0d, want 1 80 1 4", n_pl, px[0], n_ate, len2);
      else n_pass++;
      fx_a[2] = 8'd81;
      do_move(2, 2'd1, 12, 0, 2'd0);
      fv_a[2] = 1'b0;
      n_chk++;
      if (n_pl !== 2 || pn[0] !== 6 || px[0] !== 77 || pc[0] !== 0 || pn[1] !== 7 || px[1] !== 81 || pa[1] !== 1)
         $display("FAIL full_eat: got n=%0d x=%0d c%0d / n=%0d x=%0d ate=%0d, want n=6 77 c0 / n=7 81 ate=1",
                  pn[0], px[0], pc[0], pn[1], px[1], pa[1]);
      else n_pass++;
      n_chk++;
      if (n_ate !== 1 || len2 !== 3'd4)
         $display("FAIL full_len: ate pulses=%0d len=%0d, want 1 4", n_ate, len2);
      else n_pass++;
   endtask

   task automatic test_wall;
      for (int i = 0; i < 78; i++) do_move(2, 2'd1, 12, 0, 2'd0);
      n_chk++;
      if (px[1] !== 159 || dead_a[2] !== 1'b0)
         $display("FAIL wall_approach: head x=%0d dead=%b, want 159 0", px[1], dead_a[2]);
      else n_pass++;
      do_move(2, 2'd1, 12, 0, 2'd0);
      n_chk++;
      if (n_pl !== 1 || pn[0] !== 1 || px[0] !== 159 || py[0] !== 59 || pc[0] !== 4 || dead_a[2] !== 1'b1 || busy_a[2] !== 1'b0)
         $display("FAIL wall_dead: got plots=%0d n=%0d (%0d,%0d) c%0d dead=%b busy=%b, want 1 n=1 (159,59) c4 1 0",
                  n_pl, pn[0], px[0], py[0], pc[0], dead_a[2], busy_a[2]);
      else n_pass++;
      do_move(2, 2'd2, 12, 0, 2'd0);
      n_chk++;
      if (n_pl !== 0 || dead_a[2] !== 1'b1 || busy_fall !== 1 || len2 !== 3'd4)
         $display("FAIL dead_ignore: got plots=%0d dead=%b busy low at %0d len=%0d, want 0 1 1 4", n_pl, dead_a[2], busy_fall, len2);
      else n_pass++;
   endtask

   task automatic test_wrap;
      for (int i = 0; i < 80; i++) do_move(1, 2'd1, 12, 0, 2'd0);
      do_move(1, 2'd1, 12, 0, 2'd0);
      n_chk++;
      if (n_pl !== 2 || px[0] !== 157 || pc[0] !== 0 || pn[1] !== 6 || px[1] !== 0 || py[1] !== 59 || pc[1] !== 2 || dead_a[1] !== 1'b0)
         $display("FAIL wrap: got plots=%0d erase x=%0d c%0d draw n=%0d (%0d,%0d) c%0d dead=%b, want 2 157 c0 n=6 (0,59) c2 0",
                  n_pl, px[0], pc[0], pn[1], px[1], py[1], pc[1], dead_a[1]);
      else n_pass++;
   endtask

   initial begin
      test_reset;
      test_step;
      test_reversal;
      test_back_to_back;
      test_food;
      test_self;
      test_full_length;
      test_wall;
      test_wrap;
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/snake_engine.md
# snake_engine

Parametrised snake body engine for the VGA snake game. It stores the body in a circular position buffer and advances one cell per `step` pulse. It detects wall and self collisions and grows when the new head lands on the food cell. Its output is a one-pixel-per-cycle plot stream (tail erase, head draw) that drives the `vga_adapter` x/y/colour/plot inputs directly.

## Interface
- `X_W`, default 8: x coordinate width.
- `Y_W`, default 7: y coordinate width.
- `X_MAX`, default 159: largest legal x.
- `Y_MAX`, default 119: largest legal y.
- `MAX_LEN`, default 64: buffer depth; power of 2, ≥ `INIT_LEN`.
- `INIT_LEN`, default 3: body length after reset; 1..8.
- `WRAP`, default 0: 0 = leaving the grid kills the snake; 1 = edges wrap around.
- `clk` in 1: clock.
- `resetn` in 1: asynchronous, active-low reset.
- `step` in 1: one-cycle advance request; honoured only in IDLE.
- `dir_req` in 2: requested direction, sampled with `step`. 0 = left, 1 = right, 2 = up, 3 = down.
- `food_valid` in 1: `food_x`/`food_y` hold a live food cell.
- `food_x` in X_W, `food_y` in Y_W: food position.
- `plot` out 1: pixel write strobe.
- `x_out` out X_W, `y_out` out Y_W, `colour` out 3: pixel data, valid while `plot`=1.
- `busy` out 1: engine not in IDLE/DEAD.
- `ate` out 1: one-cycle pulse on growth/eat.
- `dead` out 1: sticky collision flag.
- `length` out log2(MAX_LEN)+1: current body length.

## Operation
- **Reset values:** `plot`=0, `x_out`=0, `y_out`=0, `colour`=0, `busy`=0, `ate`=0, `dead`=0, `length`=INIT_LEN, direction=right.
  - Segment k (0 = head) = (X0−k, Y0), with X0 = X_MAX/2 and Y0 = Y_MAX/2 (integer division).
  - Reset mid-operation aborts any state immediately.
- **Buffer:** `MAX_LEN`-entry circular RAM of {x,y}.
  - Head pointer `hp`; tail index = `hp`−`length`+1 mod MAX_LEN.
  - A new head is written at `hp`+1; pointer arithmetic wraps modulo MAX_LEN.
- **States:** INIT → IDLE → CALC → SCAN → ERASE → DRAW → IDLE; DEAD is terminal.
- **INIT:** entered on the first clk after reset release.
  - Plots the INIT_LEN segments, head first, one per cycle, colour 3'b010.
  - `busy`=1 throughout; then IDLE.
- **IDLE:** on `step`=1 and not dead, latch the direction, then go to CALC.
  - `dir_req` opposite to the current direction is ignored; the current direction is kept.
- **CALC:** compute the next head nh = head ± 1 on the axis of the direction.
  - If WRAP=0 and the move leaves 0..X_MAX or 0..Y_MAX, go to DEAD.
  - If WRAP=1: x 0 going left becomes X_MAX; X_MAX going right becomes 0; same rule for y.
  - grow = `food_valid` && nh == food.
- **SCAN:** `length` cycles, one buffer entry per cycle, oldest to head.
  - Compare each entry with nh; any match means collision.
  - The tail entry is excluded when grow=0, because the tail vacates.
  - Collision → DEAD after the scan completes.
- **ERASE:** plot the tail with colour 3'b000.
  - Skipped if grow=1 and `length` < MAX_LEN.
  - Otherwise drop the tail.
- **DRAW:** write nh at `hp`+1, plot nh with colour 3'b010, advance `hp`.
  - If grow: `length`+1 (saturates at MAX_LEN) and pulse `ate`.
  - Then IDLE.
- **DEAD:** on entry, one `plot` of the current head with colour 3'b100; `dead`=1, `busy`=0.
  - Stays in DEAD until reset; `step` is ignored.
- **Grow at full length:** when grow=1 and `length`==MAX_LEN, `ate` still pulses, the tail is erased and `length` stays at MAX_LEN.

## Timing
- `step` sampled at edge T (IDLE).
  - CALC at T+1.
  - SCAN at T+2 .. T+1+`length`.
  - ERASE pixel at cycle T+2+`length`.
  - DRAW pixel one cycle after ERASE, or at T+2+`length` when ERASE is skipped.
- `busy` rises the cycle after `step` is accepted and falls the cycle after DRAW.
- `step` while `busy` is dropped, not queued.
- `plot` is high exactly one cycle per pixel; `x_out`/`y_out`/`colour` are registered and valid in that same cycle.
- `ate` is coincident with the DRAW `plot`; `dead` rises with the DEAD `plot` and never falls without reset.
- INIT lasts INIT_LEN cycles, so the first `step` can be accepted at cycle INIT_LEN+1 after reset release.

## Test plan
- **Reset, default params:** 3 plots (79,59), (78,59), (77,59) with colour 2; `length`=3; `busy` low after 3 cycles.
- **Step with `dir_req`=1:** erase (77,59) colour 0 at T+5, draw (80,59) colour 2 at T+6; `length`=3.
- **Reversal and busy:** `dir_req`=0 while moving right → snake continues right. A `step` pulse during `busy` → no extra move.
- **Food at (80,59), `food_valid`=1, step right:** no erase; draw (80,59); `ate` pulse; `length`=4.
- **Edges:** WRAP=0, head steps right from x=159 → red plot at the current head, `dead`=1, later steps ignored. WRAP=1, same move → head drawn at (0,y).
- **Self and full length:**
  - Length-5 snake steered right-down-left-up into its own body → `dead`=1.
  - MAX_LEN=4 at length 4 eating food → `ate` pulses, tail erased, `length` stays 4.
